// File: rtl/bus_arbiter_n.sv
// N-master bus arbiter: fixed-priority or round-robin selection, registered one-hot ack.
// Define ARB_TENURE_LIMIT_EN to compile in tenure-limit preemption with per-master lock.
module bus_arbiter_n #(
   parameter int unsigned N_MASTERS  = 4,
   parameter int unsigned MAX_TENURE = 8,
   localparam int unsigned ID_W      = $clog2(N_MASTERS)
) (
   input  logic                 clk,
   input  logic                 reset_n,
   input  logic [N_MASTERS-1:0] req,
   input  logic [N_MASTERS-1:0] lock,
   input  logic                 rr_mode,
   output logic [N_MASTERS-1:0] ack,
   output logic [ID_W-1:0]      grant_id,
   output logic                 bus_busy
);

`ifdef ARB_TENURE_LIMIT_EN
   typedef enum logic [1:0] {StIdle, StGrant, StPreempt} state_e;
   localparam logic [7:0] TenureLast = 8'(MAX_TENURE - 1);
`else
   typedef enum logic [0:0] {StIdle, StGrant} state_e;
   localparam int unsigned unused_max_tenure = MAX_TENURE;
   logic unused_lock;
   assign unused_lock = ^lock;
`endif

   state_e                 state_q, state_d;
   logic [ID_W-1:0]        owner_q, owner_d;
   logic [ID_W-1:0]        ptr_q, ptr_d;
`ifdef ARB_TENURE_LIMIT_EN
   logic [7:0]             tenure_q, tenure_d;
   logic [7:0]             tenure_sat;
`endif
   logic [N_MASTERS-1:0]   owner_oh;
   logic [N_MASTERS-1:0]   others;
   logic [ID_W:0]          win_all;
   logic [ID_W:0]          win_oth;

   // Returns {found, index}; round-robin search starts just after ptr.
   function automatic logic [ID_W:0] pick(input logic [N_MASTERS-1:0] cand,
                                           input logic rr, input logic [ID_W-1:0] ptr);
      logic            found;
      logic [ID_W-1:0] idx;
      logic [ID_W-1:0] idx_c;
      logic [31:0]     j;
      found = 1'b0;
      idx   = '0;
      for (int unsigned i = 0; i < N_MASTERS; i++) begin
         j     = rr ? (32'(ptr) + i + 32'd1) % N_MASTERS : i;
         idx_c = j[ID_W-1:0];
         if (!found && cand[idx_c]) begin
            found = 1'b1;
            idx   = idx_c;
         end
      end
      return {found, idx};
   endfunction

   assign owner_oh = N_MASTERS'(1) << owner_q;
   assign others   = req & ~owner_oh;
   assign win_all  = pick(req, rr_mode, ptr_q);
   assign win_oth  = pick(others, rr_mode, ptr_q);
`ifdef ARB_TENURE_LIMIT_EN
   assign tenure_sat = (tenure_q == TenureLast) ? tenure_q : tenure_q + 8'd1;
`endif

   always_comb begin
      state_d = state_q;
      owner_d = owner_q;
      ptr_d   = ptr_q;
`ifdef ARB_TENURE_LIMIT_EN
      tenure_d = tenure_q;
`endif
      case (state_q)
         StIdle: begin
            if (win_all[ID_W]) begin
               state_d = StGrant;
               owner_d = win_all[ID_W-1:0];
               ptr_d   = win_all[ID_W-1:0];
`ifdef ARB_TENURE_LIMIT_EN
               tenure_d = 8'd0;
`endif
            end
         end
         StGrant: begin
            if (!req[owner_q]) begin
               // Handover straight to the next winner, no dead cycle.
               if (win_oth[ID_W]) begin
                  owner_d = win_oth[ID_W-1:0];
                  ptr_d   = win_oth[ID_W-1:0];
`ifdef ARB_TENURE_LIMIT_EN
                  tenure_d = 8'd0;
`endif
               end else begin
                  state_d = StIdle;
               end
            end else begin
`ifdef ARB_TENURE_LIMIT_EN
               if (!lock[owner_q] && tenure_q == TenureLast && |others) begin
                  state_d = StPreempt;
               end else begin
                  tenure_d = tenure_sat;
               end
`endif
            end
         end
`ifdef ARB_TENURE_LIMIT_EN
         StPreempt: begin
            // owner_q still holds the preempted master here.
            tenure_d = 8'd0;
            if (win_oth[ID_W]) begin
               state_d = StGrant;
               owner_d = win_oth[ID_W-1:0];
               ptr_d   = win_oth[ID_W-1:0];
            end else if (req[owner_q]) begin
               state_d = StGrant;
               ptr_d   = owner_q;
            end else begin
               state_d = StIdle;
            end
         end
`endif
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= StIdle;
         owner_q <= '0;
         ptr_q   <= ID_W'(N_MASTERS - 1);
`ifdef ARB_TENURE_LIMIT_EN
         tenure_q <= 8'd0;
`endif
      end else begin
         state_q <= state_d;
         owner_q <= owner_d;
         ptr_q   <= ptr_d;
`ifdef ARB_TENURE_LIMIT_EN
         tenure_q <= tenure_d;
`endif
      end
   end

   always_comb begin
      bus_busy = (state_q == StGrant);
      ack      = bus_busy ? owner_oh : '0;
      grant_id = bus_busy ? owner_q : '0;
   end

endmodule

// File: tb/tb_bus_arbiter_n.sv
// Self-checking bench for bus_arbiter_n (N_MASTERS=4, MAX_TENURE=4): directed vectors plus
// a cycle-level reference model compared on every falling edge.
module tb_bus_arbiter_n;

   localparam int N   = 4;
   localparam int MAX = 4;

   logic         clk;
   logic         reset_n;
   logic [N-1:0] req;
   logic [N-1:0] lock;
   logic         rr_mode;
   logic [N-1:0] ack;
   logic [1:0]   grant_id;
   logic         bus_busy;

   int checks = 0;
   int errors = 0;

   bus_arbiter_n #(.N_MASTERS(N), .MAX_TENURE(MAX)) dut (
      .clk      (clk),
      .reset_n  (reset_n),
      .req      (req),
      .lock     (lock),
      .rr_mode  (rr_mode),
      .ack      (ack),
      .grant_id (grant_id),
      .bus_busy (bus_busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // owner = -1 when nobody holds the bus; held = ack cycles granted so far.
   typedef struct {
      int owner;
      int prev;
      int ptr;
      int held;
      bit gap;
   } model_t;

   model_t m = '{owner: -1, prev: 0, ptr: N - 1, held: 0, gap: 1'b0};

   function automatic int winner(logic [N-1:0] msk, bit rr, int p);
      if (msk == '0) return -1;
      for (int k = 0; k < N; k++) begin
         int j;
         j = rr ? (p + 1 + k) % N : k;
         if (msk[j]) return j;
      end
      return -1;
   endfunction

   function automatic model_t give(model_t s, int w);
      model_t n = s;
      if (w < 0) begin
         n.owner = -1;
      end else begin
         n.owner = w;
         n.ptr   = w;
         n.held  = 1;
      end
      return n;
   endfunction

   function automatic model_t step(model_t s, logic [N-1:0] rq, logic [N-1:0] lk, bit rr);
      model_t       n = s;
      logic [N-1:0] oth;
      int           w;
      if (s.gap) begin
         n.gap = 1'b0;
         oth   = rq & ~(4'b0001 << s.prev);
         w     = winner(oth, rr, s.ptr);
         if (w < 0 && rq[s.prev]) w = s.prev;
         n = give(n, w);
      end else if (s.owner < 0) begin
         n = give(n, winner(rq, rr, s.ptr));
      end else begin
         oth = rq & ~(4'b0001 << s.owner);
         if (!rq[s.owner]) begin
            n = give(n, winner(oth, rr, s.ptr));
`ifdef ARB_TENURE_LIMIT_EN
         end else if (!lk[s.owner] && s.held >= MAX && oth != '0) begin
            n.gap   = 1'b1;
            n.prev  = s.owner;
            n.owner = -1;
`endif
         end else begin
            n.held = s.held + 1;
         end
      end
      return n;
   endfunction

   always @(posedge clk or negedge reset_n) begin
      if (!reset_n) m <= '{owner: -1, prev: 0, ptr: N - 1, held: 0, gap: 1'b0};
      else          m <= step(m, req, lock, rr_mode);
   end

   task automatic check(string nm, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   always @(negedge clk) begin
      logic [N-1:0] exp_ack;
      exp_ack = (m.owner < 0) ? 4'b0000 : (4'b0001 << m.owner);
      check("model_ack", 32'(ack), 32'(exp_ack));
      check("model_busy", 32'(bus_busy), 32'(m.owner >= 0));
      if (m.owner >= 0) check("model_grant_id", 32'(grant_id), 32'(m.owner));
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
`ifdef ARB_TENURE_LIMIT_EN
      logic [N-1:0] exp_seq [6] = '{4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0000, 4'b1000};
`endif
      reset_n = 1'b0;
      req     = 4'b1111;
      lock    = 4'b0000;
      rr_mode = 1'b0;
      repeat (3) tick();
      check("reset_ack", 32'(ack), 32'h0);
      check("reset_grant_id", 32'(grant_id), 32'h0);
      check("reset_busy", 32'(bus_busy), 32'h0);
      req     = 4'b0000;
      reset_n = 1'b1;
      tick();

      // Fixed priority and gapless handover
      req = 4'b1010;
      tick();
      check("fp_ack", 32'(ack), 32'h2);
      check("fp_grant_id", 32'(grant_id), 32'h1);
      req = 4'b1000;
      tick();
      check("handover_ack", 32'(ack), 32'h8);
      check("handover_grant_id", 32'(grant_id), 32'h3);
      req = 4'b0000;
      tick();
      check("idle_ack", 32'(ack), 32'h0);

      // Round-robin vs fixed priority on the same owner drop
      rr_mode = 1'b1;
      req     = 4'b0010;
      tick();
      check("rr_first_ack", 32'(ack), 32'h2);
      req = 4'b1101;
      tick();
      check("rr_next_ack", 32'(ack), 32'h4);
      req = 4'b0000;
      tick();
      rr_mode = 1'b0;
      req     = 4'b0010;
      tick();
      check("fp_first_ack", 32'(ack), 32'h2);
      req = 4'b1101;
      tick();
      check("fp_next_ack", 32'(ack), 32'h1);
      req = 4'b0000;
      tick();

`ifdef ARB_TENURE_LIMIT_EN
      // Tenure expiry: MAX cycles of ack, one empty cycle, then the next master
      req = 4'b1001;
      for (int i = 0; i < 6; i++) begin
         tick();
         check($sformatf("expiry_ack[%0d]", i), 32'(ack), 32'(exp_seq[i]));
      end
      req = 4'b0000;
      tick();

      // Locked owner keeps the bus; unlocking preempts on the next edge
      lock = 4'b0001;
      req  = 4'b1001;
      for (int i = 0; i < 22; i++) begin
         tick();
         check($sformatf("lock_ack[%0d]", i), 32'(ack), 32'h1);
      end
      lock = 4'b0000;
      tick();
      check("unlock_gap_ack", 32'(ack), 32'h0);
      tick();
      check("unlock_next_ack", 32'(ack), 32'h8);
      req = 4'b0000;
      tick();
`else
      // Without the tenure limit the owner keeps the bus while it requests
      req = 4'b1001;
      for (int i = 0; i < 20; i++) begin
         tick();
         check($sformatf("hold_ack[%0d]", i), 32'(ack), 32'h1);
      end
      req = 4'b0000;
      tick();
`endif

      // Asynchronous reset mid-grant clears outputs before the next edge
      req = 4'b0100;
      tick();
      check("pre_reset_ack", 32'(ack), 32'h4);
      #2 reset_n = 1'b0;
      #1;
      check("async_reset_ack", 32'(ack), 32'h0);
      check("async_reset_busy", 32'(bus_busy), 32'h0);
      check("async_reset_grant_id", 32'(grant_id), 32'h0);
      #2 reset_n = 1'b1;
      tick();
      check("post_reset_ack", 32'(ack), 32'h4);
      req = 4'b0000;
      repeat (2) tick();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
